// File: rtl/spi_master_shifter.sv
// SPI mode-0 (CPOL=0, CPHA=0) master shift engine.
// Takes one W_DATA-bit word over a valid/ready handshake, shifts it out MSB-first
// on mosi while capturing miso, and returns the received word with a one-cycle
// rx_valid pulse. All outputs are registered.
module spi_master_shifter #(
  parameter int W_DATA  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [W_DATA-1:0] tx_data,
  output logic              rx_valid,
  output logic [W_DATA-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = (W_DATA  > 1) ? $clog2(W_DATA)  : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(W_DATA - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state;
  logic [W_DATA-1:0] tx_sr;
  logic [W_DATA-1:0] rx_sr;
  logic [BW-1:0]     bit_cnt;
  logic [DW-1:0]     div_cnt;
  logic              tick;

  // Terminal count of the half-period divider; every timed step keys off this.
  assign tick = (div_cnt == DIV_LAST);

  // Whole engine: frame sequencing, sclk generation, shift registers and
  // registered handshake outputs. An async reset aborts any frame in flight,
  // deselects the slave and clears the received word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;

      if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_sr    <= tx_data;
            cs_n     <= 1'b0;
            mosi     <= tx_data[W_DATA-1];
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[W_DATA-2:0], miso};
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[W_DATA-2:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state <= HOLD;
              end else begin
                tx_sr   <= tx_sr << 1;
                mosi    <= tx_sr[W_DATA-2];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        HOLD: begin
          if (tick) begin
            cs_n     <= 1'b1;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            state    <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            mosi     <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          sclk     <= 1'b0;
          cs_n     <= 1'b1;
          mosi     <= 1'b0;
          div_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter (W_DATA=32, CLK_DIV=4).
// Stimulus pushes the expected received word and completion cycle into a
// scoreboard queue; an independent monitor pops and compares on each rx_valid.
module tb_spi_master_shifter;

  localparam int W   = 32;
  localparam int DIV = 4;
  localparam int DONE_LAT  = (2 * W + 1) * DIV;
  localparam int READY_LAT = (2 * W + 2) * DIV;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    bit           chk_zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] tx_data = '0;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [1:0]   miso_mode = 2'd0;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  int   rise_cnt = 0;
  bit   mosi_hi = 1'b0;
  bit   prev_sclk = 1'b0;
  bit   prev_rxv = 1'b0;
  bit   prev_cs = 1'b1;
  int   hi_run = 0;
  int   last_gap = 0;

  // miso source: 0 = looped back from mosi, 1 = stuck high, 2 = stuck low
  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1);

  spi_master_shifter #(.W_DATA(W), .CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Posedge counter used as the timing reference for all cycle checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Waits (from a negedge) for a cycle where the handshake will complete on the
  // next posedge, then records the accept cycle and queues the expected result.
  task automatic waitAccept(input logic [W-1:0] exp_data, input bit chk_zero);
    int n = 0;
    while (!(tx_ready && tx_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      timeoutFail("accept");
    end else begin
      exp_t e;
      last_acc   = cyc + 1;
      e.data     = exp_data;
      e.cyc      = last_acc + DONE_LAT;
      e.chk_zero = chk_zero;
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input logic [W-1:0] exp_data,
                               input bit chk_zero, input bit hold);
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    waitAccept(exp_data, chk_zero);
    @(negedge clk);
    tx_valid = hold;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(sb.size() == 0 && tx_ready && !busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeoutFail("idle");
  endtask

  // Monitor: compares every rx_valid pulse against the scoreboard head and keeps
  // per-frame observations (sclk rising edges, mosi activity, cs_n gap length).
  always @(negedge clk) begin
    if (rst) begin
      rise_cnt  = 0;
      mosi_hi   = 1'b0;
      prev_sclk = 1'b0;
      prev_rxv  = 1'b0;
      prev_cs   = 1'b1;
      hi_run    = 0;
    end else begin
      if (sclk && !prev_sclk) rise_cnt++;
      if (mosi && !cs_n) mosi_hi = 1'b1;
      if (cs_n) begin
        hi_run++;
      end else begin
        if (prev_cs) last_gap = hi_run;
        hi_run = 0;
      end
      if (rx_valid) begin
        checkOutput("rx_valid_single_pulse", {31'd0, prev_rxv}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_rx_valid: got rx_data %h, expected no completion", rx_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("rx_data", rx_data, e.data);
          checkOutput("rx_valid_cycle", W'(cyc), W'(e.cyc));
          checkOutput("sclk_rising_edges", W'(rise_cnt), W'(W));
          if (e.chk_zero) checkOutput("mosi_low_whole_frame", {31'd0, mosi_hi}, 32'd0);
        end
        rise_cnt = 0;
        mosi_hi  = 1'b0;
      end
      prev_sclk = sclk;
      prev_rxv  = rx_valid;
      prev_cs   = cs_n;
    end
  end

  // Watchdog so the run always ends with a summary
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    n_checks++;
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int acc1;

    // 1: reset state, including a mid-cycle reset pulse while idle
    @(negedge clk);
    checkOutput("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_cs_n", {31'd0, cs_n}, 32'd1);
    checkOutput("reset_sclk_mosi_busy_rxv", {28'd0, sclk, mosi, busy, rx_valid}, 32'd0);
    checkOutput("reset_rx_data", rx_data, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("midcycle_reset_outputs", {26'd0, tx_ready, cs_n, sclk, mosi, rx_valid, busy},
                   32'b110000);
    @(negedge clk);
    rst = 1'b0;

    // 2: loopback frame, latency of completion and ready
    miso_mode = 2'd0;
    applyStimulus(32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 1'b0);
    acc1 = last_acc;
    checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
    waitCycle(acc1 + READY_LAT - 1);
    checkOutput("tx_ready_before_264", {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    checkOutput("tx_ready_at_264", {31'd0, tx_ready}, 32'd1);
    checkOutput("busy_at_264", {31'd0, busy}, 32'd0);
    waitIdle();

    // 3: constant miso levels against opposite mosi data
    miso_mode = 2'd1;
    applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    waitIdle();
    miso_mode = 2'd2;
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    waitIdle();
    checkOutput("mosi_idle_low", {31'd0, mosi}, 32'd0);

    // 4: back-to-back with tx_valid held high; the second handshake completes
    // on the posedge closing the first IDLE cycle, so cs_n stays high for the
    // CLK_DIV-cycle GAP plus that IDLE cycle
    miso_mode = 2'd0;
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    acc1 = last_acc;
    tx_data = 32'hDEAD_BEEF;
    waitAccept(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("b2b_accept_cycle", W'(last_acc - acc1), W'(READY_LAT + 1));
    waitIdle();
    checkOutput("b2b_cs_n_gap", W'(last_gap), W'(DIV + 1));

    // 5: tx_valid pulse in mid-frame is ignored
    applyStimulus(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);
    acc1 = last_acc;
    waitCycle(acc1 + 50);
    tx_data  = 32'h0BAD_0BAD;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    waitIdle();
    repeat (20) @(negedge clk);
    checkOutput("no_extra_frame", {30'd0, cs_n, busy}, 32'b10);

    // 6: reset in mid-frame aborts immediately, then a fresh frame completes
    applyStimulus(32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 1'b0);
    acc1 = last_acc;
    waitCycle(acc1 + 100);
    #2 rst = 1'b1;
    #1 checkOutput("abort_outputs", {26'd0, tx_ready, cs_n, sclk, mosi, rx_valid, busy},
                   32'b110000);
    checkOutput("abort_rx_data", rx_data, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    waitIdle();
    checkOutput("final_rx_data_held", rx_data, 32'h0000_0001);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
